// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit scheduler.
//                Holds the transmit sequencer state encoding and the byte
//                width used on every data path of the scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Width of one UART payload byte.
    localparam int UART_BYTE_W = 8;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } uart_tx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_fifo
//  Description : Synchronous single-clock FIFO for the UART transmit path.
//                Pushes into a full FIFO and pops from an empty FIFO are
//                ignored. The head entry is visible combinationally on
//                data_o. Pointers wrap modulo DEPTH, so DEPTH must be a
//                power of two and at least 2.
//  Ports       : clk, rst      clock, asynchronous active-high reset
//                push_i/data_i write request and byte
//                pop_i         read request (head is on data_o)
//                count_o       occupancy, 0..DEPTH
//                empty_o/full_o status flags
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic w_push;
    logic w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_full_count);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Guard requests against overflow/underflow so the pointers never skew.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : uart_byte_fifo
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmitter between two byte requesters.
//                req0 (core store path) and req1 (debug/printf path) are
//                arbitrated round-robin into a byte FIFO. A four-state
//                sequencer pops each byte into tx_data, pulses tx_start for
//                one cycle, waits for tx_done (bounded by TIMEOUT) and then
//                inserts GAP_CYCLES idle cycles before the next frame.
//  Ports       : clk, rst              clock, asynchronous active-high reset
//                reqN_valid/data/ready requester handshakes (ready is the
//                                      combinational grant for this cycle)
//                tx_data/tx_start      byte and start pulse to transmitter
//                tx_done               frame complete from transmitter
//                irq_en, tx_idle_int   idle interrupt enable / level output
//                err_clr, err_timeout  sticky timeout error and its clear
//                fifo_count/empty/full FIFO status
//                tx_active             sequencer is not idle
//  Config      : `define UART_TX_SCHED_STATS_EN adds the 16-bit byte_count
//                output counting frames completed by tx_done.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [UART_BYTE_W-1:0] req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [UART_BYTE_W-1:0] req1_data,
    output logic                   req1_ready,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_start,
    input  logic                   tx_done,
    input  logic                   irq_en,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic                   tx_active,
    output logic                   tx_idle_int,
`ifdef UART_TX_SCHED_STATS_EN
    output logic                   err_timeout,
    output logic [15:0]            byte_count
`else
    output logic                   err_timeout
`endif
);

    // Counter widths: the gap counter holds GAP_CYCLES (at least one bit
    // even when GAP_CYCLES is 0); the timeout counter holds TIMEOUT-1.
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] c_gap_load = GW'(GAP_CYCLES);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic                   rr_q, rr_d;       // 0: req0 wins next contention
    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_push;
    logic [UART_BYTE_W-1:0] w_push_data;

    // Grants look only at fifo_full, never at a same-cycle pop, so a full
    // FIFO always stalls both requesters for at least one cycle.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        rr_d     = rr_q;
        if (!fifo_full) begin
            if (req0_valid && req1_valid) begin
                if (rr_q == 1'b0) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
                // Priority only rotates when both actually competed.
                rr_d = ~rr_q;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign w_push      = w_grant0 | w_grant1;
    assign w_push_data = w_grant0 ? req0_data : req1_data;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic                   w_pop;
    logic [UART_BYTE_W-1:0] w_head;

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // ------------------------------------------------------------------
    // Transmit sequencer
    // ------------------------------------------------------------------
    uart_tx_state_e         state_q, state_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   err_q, err_d;
    logic                   w_done_acc;       // tx_done accepted in WAIT
    logic                   w_tmo_evt;        // WAIT ran out of cycles

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        w_pop      = 1'b0;
        w_done_acc = 1'b0;
        w_tmo_evt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    w_pop     = 1'b1;
                    tx_data_d = w_head;
                    state_d   = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    w_done_acc = 1'b1;
                end else if (tmo_q == c_tmo_last) begin
                    w_tmo_evt = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                // A timeout finishes the frame exactly like a done would.
                if (w_done_acc || w_tmo_evt) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = c_gap_load;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q == GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A timeout in the same cycle as err_clr must leave the flag set.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (w_tmo_evt) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            tmo_q     <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
            rr_q      <= rr_d;
        end
    end

    // Outputs are decoded from registers only, so an asynchronous reset
    // drops tx_start without waiting for a clock edge.
    assign tx_data     = tx_data_q;
    assign tx_start    = (state_q == START);
    assign tx_active   = (state_q != IDLE);
    assign tx_idle_int = irq_en & fifo_empty & (state_q == IDLE);
    assign err_timeout = err_q;

`ifdef UART_TX_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Completed-frame counter; timeouts are not counted.
    // ------------------------------------------------------------------
    logic [15:0] byte_count_q, byte_count_d;

    always_comb begin
        byte_count_d = byte_count_q;
        if (w_done_acc) begin
            byte_count_d = byte_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler (DEPTH=8,
//                GAP_CYCLES=2, TIMEOUT=16). Arbitration is driven from a
//                vector table; single-byte latency, FIFO full, timeout,
//                idle interrupt and mid-frame reset are hand sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic       irq_en  = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       tx_active;
    logic       tx_idle_int;
    logic       err_timeout;
`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] byte_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .DEPTH      (8),
        .GAP_CYCLES (2),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .irq_en      (irq_en),
        .err_clr     (err_clr),
        .fifo_count  (fifo_count),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .tx_active   (tx_active),
        .tx_idle_int (tx_idle_int),
`ifdef UART_TX_SCHED_STATS_EN
        .err_timeout (err_timeout),
        .byte_count  (byte_count)
`else
        .err_timeout (err_timeout)
`endif
    );

    typedef struct packed {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;     // expected req0_ready
        logic       r1;     // expected req1_ready
        logic [7:0] cnt;    // expected fifo_count after the edge
    } vec_t;

    vec_t       vt [8];
    logic [7:0] expq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one frame: optionally wait for its start pulse, check the byte,
    // then return tx_done while the sequencer is in WAIT.
    task automatic serve(input logic [7:0] exp, input bit in_wait, input string name);
        int n = 0;
        if (!in_wait) begin
            while (!tx_start && n < 60) begin
                tick();
                n++;
            end
            chk({name, " start"}, 32'(tx_start), 32'd1);
            chk({name, " data"}, 32'(tx_data), 32'(exp));
            tick();
        end else begin
            chk({name, " data"}, 32'(tx_data), 32'(exp));
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tx_active && n < 60) begin
            tick();
            n++;
        end
        chk({name, " idle"}, 32'(tx_active), 32'd0);
        chk({name, " empty"}, 32'(fifo_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int m;

        // ---------------- reset state ----------------
        #12;
        chk("rst tx_start", 32'(tx_start), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst count", 32'(fifo_count), 32'd0);
        chk("rst empty", 32'(fifo_empty), 32'd1);
        chk("rst full", 32'(fifo_full), 32'd0);
        chk("rst active", 32'(tx_active), 32'd0);
        chk("rst err", 32'(err_timeout), 32'd0);
`ifdef UART_TX_SCHED_STATS_EN
        chk("rst byte_count", 32'(byte_count), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        tick();

        // ---------------- single byte latency ----------------
        req0_valid = 1'b1;
        req0_data  = 8'h41;
        #1;
        chk("single ready0", 32'(req0_ready), 32'd1);
        chk("single ready1", 32'(req1_ready), 32'd0);
        tick();                                   // push edge N
        req0_valid = 1'b0;
        chk("single N count", 32'(fifo_count), 32'd1);
        chk("single N start", 32'(tx_start), 32'd0);
        tick();                                   // N+1: popped
        chk("single N+1 start", 32'(tx_start), 32'd1);
        chk("single N+1 data", 32'(tx_data), 32'h41);
        chk("single N+1 count", 32'(fifo_count), 32'd0);
        tick();                                   // N+2
        chk("single N+2 start", 32'(tx_start), 32'd0);
        chk("single N+2 active", 32'(tx_active), 32'd1);
        repeat (10) tick();
        tx_done = 1'b1;
        tick();                                   // done edge D
        tx_done = 1'b0;
        chk("single gap1 active", 32'(tx_active), 32'd1);
        tick();
        chk("single gap2 active", 32'(tx_active), 32'd1);
        tick();
        chk("single idle", 32'(tx_active), 32'd0);
        chk("single data hold", 32'(tx_data), 32'h41);

        // ---------------- arbitration table ----------------
        //            v0    d0     v1    d1     r0    r1    cnt
        vt[0] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1};
        vt[1] = '{1'b0, 8'h00, 1'b1, 8'h82, 1'b0, 1'b1, 8'd1};
        vt[2] = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b0, 8'd2};
        vt[3] = '{1'b1, 8'h11, 1'b1, 8'h20, 1'b0, 1'b1, 8'd3};
        vt[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd3};
        vt[5] = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b0, 8'd4};
        vt[6] = '{1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 1'b1, 8'd5};
        vt[7] = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 1'b1, 8'd6};
        for (int i = 0; i < 8; i++) begin
            req0_valid = vt[i].v0;
            req0_data  = vt[i].d0;
            req1_valid = vt[i].v1;
            req1_data  = vt[i].d1;
            #1;
            chk($sformatf("arb[%0d] ready0", i), 32'(req0_ready), 32'(vt[i].r0));
            chk($sformatf("arb[%0d] ready1", i), 32'(req1_ready), 32'(vt[i].r1));
            if (vt[i].r0) expq.push_back(vt[i].d0);
            if (vt[i].r1) expq.push_back(vt[i].d1);
            tick();
            chk($sformatf("arb[%0d] count", i), 32'(fifo_count), 32'(vt[i].cnt));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        foreach (expq[k]) begin
            serve(expq[k], (k == 0), $sformatf("order[%0d]", k));
        end
        wait_idle("arb");

        // ---------------- FIFO full ----------------
        req0_valid = 1'b1;
        req0_data  = 8'hB0;
        tick();
        req0_valid = 1'b0;
        n = 0;
        while (!tx_start && n < 20) begin
            tick();
            n++;
        end
        chk("full B0 start", 32'(tx_start), 32'd1);
        tick();                                   // B0 now in WAIT
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1'b1;
            req0_data  = 8'hC0 + 8'(i);
            #1;
            chk($sformatf("full push%0d ready0", i), 32'(req0_ready), 32'd1);
            tick();
        end
        req0_data  = 8'hC8;
        req1_valid = 1'b1;
        req1_data  = 8'hD0;
        #1;
        chk("full flag", 32'(fifo_full), 32'd1);
        chk("full count", 32'(fifo_count), 32'd8);
        chk("full ready0", 32'(req0_ready), 32'd0);
        chk("full ready1", 32'(req1_ready), 32'd0);
        tx_done = 1'b1;                           // finish B0
        tick();
        tx_done = 1'b0;
        n = 0;
        while (fifo_count == 4'd8 && n < 20) begin
            tick();
            n++;
        end
        chk("full pop count", 32'(fifo_count), 32'd7);
        chk("full 9th ready0", 32'(req0_ready), 32'd1);
        chk("full 9th ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("full refill count", 32'(fifo_count), 32'd8);
        serve(8'hC0, 1'b1, "full[0]");
        for (int i = 1; i < 9; i++) begin
            serve(8'hC0 + 8'(i), 1'b0, $sformatf("full[%0d]", i));
        end
        wait_idle("full");

        // ---------------- timeout ----------------
        req0_valid = 1'b1;
        req0_data  = 8'hE0;
        tick();
        req0_data  = 8'hE1;
        tick();
        req0_valid = 1'b0;
        chk("tmo E0 start", 32'(tx_start), 32'd1);
        chk("tmo E0 data", 32'(tx_data), 32'hE0);
        tick();                                   // tx_start falls
        n = 0;
        while (!err_timeout && n < 40) begin
            tick();
            n++;
        end
        chk("tmo rise delay", 32'(n), 32'd16);
        m = 0;
        while (!tx_start && m < 20) begin
            tick();
            m++;
        end
        chk("tmo next start delay", 32'(m), 32'd3);
        chk("tmo E1 data", 32'(tx_data), 32'hE1);
        tick();                                   // WAIT for E1
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo cleared", 32'(err_timeout), 32'd0);
        repeat (14) tick();
        chk("tmo no early", 32'(err_timeout), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo set wins", 32'(err_timeout), 32'd1);
        wait_idle("tmo");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo final clear", 32'(err_timeout), 32'd0);

        // ---------------- idle interrupt ----------------
        chk("irq off", 32'(tx_idle_int), 32'd0);
        irq_en = 1'b1;
        #1;
        chk("irq on idle", 32'(tx_idle_int), 32'd1);
        req1_valid = 1'b1;
        req1_data  = 8'hF0;
        tick();
        chk("irq queued", 32'(tx_idle_int), 32'd0);
        req1_data  = 8'hF1;
        tick();
        req1_data  = 8'hF2;
        tick();
        req1_valid = 1'b0;
        serve(8'hF0, 1'b1, "irq[0]");
        chk("irq between", 32'(tx_idle_int), 32'd0);
        serve(8'hF1, 1'b0, "irq[1]");
        serve(8'hF2, 1'b0, "irq[2]");
        chk("irq gap1", 32'(tx_idle_int), 32'd0);
        tick();
        chk("irq gap2", 32'(tx_idle_int), 32'd0);
        tick();
        chk("irq final", 32'(tx_idle_int), 32'd1);
        irq_en = 1'b0;
        #1;
        chk("irq masked", 32'(tx_idle_int), 32'd0);
`ifdef UART_TX_SCHED_STATS_EN
        chk("stats byte_count", 32'(byte_count), 32'd21);
`endif

        // ---------------- reset mid-WAIT ----------------
        tick();
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1;
            req0_data  = 8'h30 + 8'(i);
            tick();
        end
        req0_valid = 1'b0;
        chk("mrst queued", 32'(fifo_count), 32'd4);
        chk("mrst active", 32'(tx_active), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst count", 32'(fifo_count), 32'd0);
        chk("mrst empty", 32'(fifo_empty), 32'd1);
        chk("mrst active0", 32'(tx_active), 32'd0);
        chk("mrst start", 32'(tx_start), 32'd0);
        chk("mrst data", 32'(tx_data), 32'd0);
        chk("mrst err", 32'(err_timeout), 32'd0);
`ifdef UART_TX_SCHED_STATS_EN
        chk("mrst byte_count", 32'(byte_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk("mrst stays idle", 32'(tx_active), 32'd0);
        chk("mrst stays empty", 32'(fifo_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_scheduler
`default_nettype wire
